// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// It borrows the shared EX-stage ALU for one addition per iteration and
// stalls the pipeline (busy) while it owns the ALU.
module alu_mul_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

    // The ALU add drops the carry-out; an unsigned wrap means the sum fell below hi.
    logic carry;
    assign carry = (alu_result < hi_q);

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mc_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    // Next-state, shift-add datapath and ALU borrow decode.
    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        alu_sel   = 1'b0;
        alu_srca  = '0;
        alu_srcb  = '0;
        alu_ctrl  = 3'b000;

        unique case (state_q)
            StIdle, StDone: begin
                if (start && !abort) begin
                    mc_d    = mcand;
                    hi_d    = '0;
                    lo_d    = mplier;
                    cnt_d   = '0;
                    state_d = StIter;
                end else begin
                    state_d = StIdle;
                end
            end
            StIter: begin
                alu_sel  = 1'b1;
                alu_srca = hi_q;
                alu_srcb = mc_q;
                alu_ctrl = 3'b000;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    if (lo_q[0]) begin
                        hi_d = {carry, alu_result[WIDTH-1:1]};
                        lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[WIDTH-1:1]};
                        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        // Product registers only move on entry to DONE.
                        state_d   = StDone;
                        prod_hi_d = hi_d;
                        prod_lo_d = lo_d;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        ready   = (state_q != StIter);
        busy    = (state_q == StIter);
        done    = (state_q == StDone);
        prod_hi = prod_hi_q;
        prod_lo = prod_lo_q;
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU and a
// product scoreboard popped on each done pulse.
module tb_alu_mul_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_srca;
    logic [WIDTH-1:0] alu_srcb;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod;

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mcand      (mcand),
        .mplier     (mplier),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .prod_hi    (prod_hi),
        .prod_lo    (prod_lo),
        .alu_sel    (alu_sel),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Shared ALU model: only add is exercised.
    assign alu_result = (alu_ctrl == 3'b000) ? (alu_srca + alu_srcb) : '0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check_eq("done_unexpected", {63'd0, done}, 64'd0);
            end else begin
                check_eq("product", {prod_hi, prod_lo}, exp_q.pop_front());
            end
        end
    end

    // Issue a multiply in the current cycle and follow it to its done pulse.
    // Returns in the DONE cycle, with start already low.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat;
        logic [63:0] expv;
        expv = {32'd0, a} * {32'd0, b};
        check_eq("ready_at_start", {63'd0, ready}, 64'd1);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        exp_q.push_back(expv);
        next_cycle();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (!busy || !alu_sel || ready)
                check_eq("iter_status", {61'd0, busy, alu_sel, ready}, 64'd6);
            if ({prod_hi, prod_lo} !== last_prod)
                check_eq("prod_held", {prod_hi, prod_lo}, last_prod);
            next_cycle();
            lat++;
        end
        check_eq("done_latency", 64'(lat), 64'd33);
        check_eq("done_status", {61'd0, busy, alu_sel, ready}, 64'd1);
        last_prod = expv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mcand = '0; mplier = '0;
        last_prod = '0;
        #12;
        check_eq("reset_state", {prod_hi, prod_lo}, 64'd0);
        check_eq("reset_ctrl", {60'd0, ready, busy, done, alu_sel}, 64'd8);
        reset = 1'b0;
        next_cycle();

        // 3*5: ALU borrow visible from the first ITER cycle.
        start = 1'b1; mcand = 32'd3; mplier = 32'd5;
        exp_q.push_back(64'd15);
        check_eq("alu_sel_c0", {63'd0, alu_sel}, 64'd0);
        next_cycle();
        start = 1'b0;
        check_eq("alu_srcs_c1", {alu_srca, alu_srcb}, {32'd0, 32'd3});
        for (int c = 1; c < 33; c++) begin
            if (!busy || !alu_sel) check_eq("busy_c1_32", {62'd0, busy, alu_sel}, 64'd3);
            next_cycle();
        end
        check_eq("done_c33", {61'd0, done, busy, alu_sel}, 64'd4);
        check_eq("prod_3x5", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);
        last_prod = 64'd15;
        next_cycle();
        check_eq("done_pulse_once", {63'd0, done}, 64'd0);

        // Carry recovery and zero/edge operands.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("prod_ffxff", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
        next_cycle();
        run_op(32'h1234_5678, 32'd0);
        next_cycle();
        run_op(32'h8000_0000, 32'd2);
        check_eq("prod_hi_msb", {prod_hi, prod_lo}, 64'h0000_0001_0000_0000);
        next_cycle();

        // abort with start in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; mcand = 32'd9; mplier = 32'd9;
        next_cycle();
        start = 1'b0; abort = 1'b0;
        check_eq("abort_beats_start", {63'd0, busy}, 64'd0);

        // 7*9 aborted in cycle 10, ignored start in cycle 5, new op in cycle 12.
        start = 1'b1; mcand = 32'd7; mplier = 32'd9;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin start = 1'b1; mcand = 32'd11; mplier = 32'd13; end
            if (c == 6) begin
                start = 1'b0;
                check_eq("start_ignored_srcb", {32'd0, alu_srcb}, 64'd7);
            end
            next_cycle();
        end
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check_eq("aborted_c11", {62'd0, busy, done}, 64'd0);
        check_eq("prod_after_abort", {prod_hi, prod_lo}, last_prod);
        next_cycle();
        run_op(32'd6, 32'd7);
        check_eq("prod_6x7", {32'd0, prod_lo}, 64'd42);
        next_cycle();

        // Back-to-back: second start in the first op's DONE cycle.
        run_op(32'd2, 32'd3);
        run_op(32'd4, 32'd5);
        check_eq("prod_4x5", {32'd0, prod_lo}, 64'd20);
        next_cycle();

        // Asynchronous reset mid-ITER.
        start = 1'b1; mcand = 32'd7; mplier = 32'd9;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 17; c++) next_cycle();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_prod", {prod_hi, prod_lo}, 64'd0);
        check_eq("rst_mid_ctrl", {60'd0, ready, busy, done, alu_sel}, 64'd8);
        check_eq("rst_mid_alu", {alu_srca, alu_srcb}, 64'd0);
        check_eq("rst_mid_ctrlbits", {61'd0, alu_ctrl}, 64'd0);
        #3;
        reset = 1'b0;
        last_prod = '0;
        next_cycle();
        run_op(32'd10, 32'd10);
        check_eq("prod_10x10", {prod_hi, prod_lo}, 64'd100);
        next_cycle();
        next_cycle();

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle unsigned 32x32->64 multiply sequencer. It borrows the shared ALU in the execute stage and issues one ALU addition per iteration, using a shift-add algorithm. While it owns the ALU it stalls the pipeline, then returns a registered 64-bit product with a one-cycle done pulse. It sits beside the ALU in EX, and the ALU operand/control inputs are muxed by alu_sel.

Parameters:
WIDTH, 32, operand width; must equal the ALU datapath width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a multiply; accepted only when ready=1
abort  input  1  synchronous flush; cancels any operation in progress
mcand  input  WIDTH  multiplicand, sampled on accepted start
mplier  input  WIDTH  multiplier, sampled on accepted start
ready  output  1  block can accept start (state IDLE or DONE)
busy  output  1  high in ITER; doubles as pipeline stall request
done  output  1  one-cycle pulse; product valid
prod_hi  output  WIDTH  upper half of product, held until next accepted start
prod_lo  output  WIDTH  lower half of product, held until next accepted start
alu_sel  output  1  1 = sequencer drives the ALU inputs
alu_srca  output  WIDTH  ALU SrcA while alu_sel=1, else 0
alu_srcb  output  WIDTH  ALU SrcB while alu_sel=1, else 0
alu_ctrl  output  3  ALU control; 3'b000 (add) while alu_sel=1, else 3'b000
alu_result  input  WIDTH  ALU result (combinational from alu_srca/alu_srcb)

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, prod_hi=prod_lo=0, alu_sel=0, alu_srca=alu_srcb=0, alu_ctrl=0, counter=0.
- Internal registers: mc (WIDTH), hi (WIDTH), lo (WIDTH), cnt (CNT_W).
- FSM states: IDLE, ITER, DONE.
- IDLE/DONE with start=1 and abort=0:
  - Load mc=mcand, hi=0, lo=mplier, cnt=0.
  - Next state is ITER.
- IDLE/DONE otherwise: DONE goes to IDLE and IDLE stays in IDLE.
- ITER, each cycle:
  - alu_sel=1, alu_srca=hi, alu_srcb=mc, alu_ctrl=3'b000.
  - If lo[0]=1: compute sum=alu_result and carry=(alu_result < hi), unsigned compare. Then hi <= {carry, sum[WIDTH-1:1]} and lo <= {sum[0], lo[WIDTH-1:1]}.
  - If lo[0]=0: the ALU result is ignored. hi <= {1'b0, hi[WIDTH-1:1]} and lo <= {hi[0], lo[WIDTH-1:1]}.
  - cnt <= cnt+1. When cnt==WIDTH-1, next state is DONE.
- DONE (one cycle): done=1, prod_hi=hi, prod_lo=lo. prod_* are registered outputs updated on entry to DONE.
- Latency: start high in cycle 0, ITER occupies cycles 1..WIDTH, done=1 in cycle WIDTH+1. A start in the DONE cycle is accepted; the next ITER begins at cycle WIDTH+2 (back-to-back operation, no bubble).
- start while busy=1 is ignored, and operands are not resampled.
- abort:
  - In ITER: next state is IDLE, no done pulse, prod_* unchanged.
  - In IDLE/DONE: start is ignored and the next state is IDLE. abort has priority over start.
- alu_sel/alu_srca/alu_srcb/alu_ctrl decode combinationally from state and registers, with no glitch dependency on start. alu_sel is 0 in IDLE and DONE.
- Reset mid-ITER: immediate return to IDLE and all outputs take their reset values. A partially computed product is discarded.
- Arithmetic: unsigned only. The product is exact to 2*WIDTH bits, and the carry from the ALU add is recovered via the unsigned compare.

Test Plan:
- mcand=3, mplier=5, start in cycle 0 -> busy cycles 1..32; done=1 in cycle 33; prod_hi=0x00000000, prod_lo=0x0000000F; alu_sel=1 only in cycles 1..32.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001 (checks carry recovery).
- mcand=0x12345678, mplier=0 -> prod={0,0}; no carry is ever set. Then 0x80000000*2 -> prod_hi=1, prod_lo=0.
- Start 7*9, pulse abort in cycle 10, pulse start again in cycle 12 with 6*7 -> first op produces no done; busy=0 in cycle 11; second op gives done in cycle 45 with prod_lo=42. Also check start=1 in cycle 5 of the first op is ignored.
- Back-to-back: 2*3 then start in its DONE cycle with 4*5 -> done in cycle 33 (prod_lo=6) and cycle 66 (prod_lo=20); prod_lo holds 6 through cycles 34..65.
- Assert reset asynchronously mid-ITER (cycle 17, between edges) -> all outputs at reset values immediately; after release, a new 10*10 gives prod_lo=100.
